// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches 1-clk strobes into programmable-width high windows
//
// Purpose:
//   Each strobe on pulse_in opens a window in which level_out is high for
//   max(width_cfg,1) clocks. Consecutive windows are always separated by GAP low
//   cycles. In the default build, strobes that arrive while a window or a gap is
//   in progress are counted (up to PEND_MAX) and replayed one after another.
//   When the counter is full, further strobes are dropped, and overflow reports
//   each dropped strobe for one clock.
//
// Build option:
//   PULSE_STRETCHER_RETRIG_EN - retrigger mode with no queue. A strobe during
//   HIGH restarts the window count. A strobe during GAP reopens the window on the
//   next clock. In this mode pend_cnt and overflow are tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   pulse_in   in   strobe; each high cycle is one event
//   width_cfg  in   window length in clocks, sampled on entry to HIGH (0 acts as 1)
//   level_out  out  stretched output (registered, high while in HIGH)
//   busy       out  high whenever the FSM is not IDLE
//   pend_cnt   out  number of queued strobes awaiting replay
//   overflow   out  one-clock flag: a strobe was dropped because the queue was full

module pulse_stretcher #(
    parameter int WIDTH_W  = 8,
    parameter int GAP      = 1,
    parameter int PEND_MAX = 3,
    localparam int PCW     = $clog2(PEND_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pulse_in,
    input  logic [WIDTH_W-1:0] width_cfg,
    output logic               level_out,
    output logic               busy,
    output logic [PCW-1:0]     pend_cnt,
    output logic               overflow
);

    // One counter serves both the window and the gap, so it must be wide enough for either.
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int CW = (WIDTH_W > GW) ? WIDTH_W : GW;

    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  w_load;

    // A width of 0 behaves as 1, so the reload value is never below zero.
    assign w_load = (width_cfg == '0) ? '0 : CW'(width_cfg - WIDTH_W'(1));

    assign level_out = (state_q == ST_HIGH);
    assign busy      = (state_q != ST_IDLE);

`ifdef PULSE_STRETCHER_RETRIG_EN

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pulse_in) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= w_load;
                    end
                end
                ST_HIGH: begin
                    if (pulse_in) begin
                        // Restart the count so the window extends from this strobe.
                        cnt_q <= w_load;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_GAP;
                        cnt_q   <= GAP_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (pulse_in) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= w_load;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign pend_cnt = '0;
    assign overflow = 1'b0;

`else

    localparam logic [PCW-1:0] PEND_FULL = PCW'(PEND_MAX);
    localparam logic [PCW-1:0] PEND_ONE  = PCW'(1);

    logic [PCW-1:0] pend_q;
    logic           overflow_q;
    logic           last_gap;

    // The final GAP clock is where a queued or simultaneous strobe is consumed.
    assign last_gap = (state_q == ST_GAP) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (pulse_in) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= w_load;
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_GAP;
                        cnt_q   <= GAP_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        if ((pend_q != '0) || pulse_in) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= w_load;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase

            // Queue bookkeeping while a window or gap is in progress.
            // In the last gap cycle, a live strobe is used directly. If queued
            // strobes are also waiting, one is consumed and one is added, so the
            // count does not change.
            if (state_q != ST_IDLE) begin
                if (last_gap) begin
                    if (!pulse_in && (pend_q != '0)) begin
                        pend_q <= pend_q - PEND_ONE;
                    end
                end else if (pulse_in) begin
                    if (pend_q == PEND_FULL) begin
                        overflow_q <= 1'b1;
                    end else begin
                        pend_q <= pend_q + PEND_ONE;
                    end
                end
            end
        end
    end

    assign pend_cnt = pend_q;
    assign overflow = overflow_q;

`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed scoreboard bench for pulse_stretcher
module tb_pulse_stretcher;

    logic       clk;
    logic       rst_n;
    logic       pulse_in;
    logic [7:0] width_cfg;
    logic       level_out;
    logic       busy;
    logic [1:0] pend_cnt;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int s;
        int l;
    } win_t;

    win_t win_q[$];

    pulse_stretcher #(
        .WIDTH_W  (8),
        .GAP      (1),
        .PEND_MAX (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .width_cfg (width_cfg),
        .level_out (level_out),
        .busy      (busy),
        .pend_cnt  (pend_cnt),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_win(input int s, input int l);
        win_t w;
        w.s = s;
        w.l = l;
        win_q.push_back(w);
    endtask

    // Window monitor: measures each high window and pops the expected one.
    logic prev_lvl = 1'b0;
    int   win_start = 0;
    always @(negedge clk) begin
        if (level_out && !prev_lvl) begin
            win_start = cyc;
        end else if (!level_out && prev_lvl) begin
            if (win_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL win_unexpected observed_start=%0d expected=none", win_start);
            end else begin
                win_t w;
                w = win_q.pop_front();
                chk("win_start", win_start, w.s);
                chk("win_len", cyc - win_start, w.l);
            end
        end
        prev_lvl = level_out;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            step(1);
            n++;
        end
        chk({tag, "_idle_timeout"}, int'(n < 300), 1);
        step(2);
        chk({tag, "_sb_empty"}, win_q.size(), 0);
    endtask

    initial begin
        int e;
        int peak;

        rst_n     = 1'b0;
        pulse_in  = 1'b1;
        width_cfg = 8'd3;

        // Reset with the strobe held high: everything must stay quiet.
        step(3);
        chk("rst_level", int'(level_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pend", int'(pend_cnt), 0);
        chk("rst_ovf", int'(overflow), 0);
        pulse_in = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);

        // Width 3: three high cycles, one GAP cycle, then idle.
        width_cfg = 8'd3;
        pulse_in  = 1'b1;
        e         = cyc + 1;
        push_win(e, 3);
        step(1);
        pulse_in = 1'b0;
        chk("w3_level_first", int'(level_out), 1);
        chk("w3_busy_first", int'(busy), 1);
        step(3);
        chk("w3_gap_level", int'(level_out), 0);
        chk("w3_gap_busy", int'(busy), 1);
        step(1);
        chk("w3_idle_busy", int'(busy), 0);
        wait_idle("w3");

        // A width of 0 still gives a single high cycle.
        width_cfg = 8'd0;
        pulse_in  = 1'b1;
        e         = cyc + 1;
        push_win(e, 1);
        step(1);
        pulse_in = 1'b0;
        wait_idle("w0");

`ifdef PULSE_STRETCHER_RETRIG_EN
        // A strobe two clocks into a 4-clock window extends it to 6 contiguous clocks.
        width_cfg = 8'd4;
        pulse_in  = 1'b1;
        e         = cyc + 1;
        push_win(e, 6);
        step(1);
        pulse_in = 1'b0;
        step(1);
        pulse_in = 1'b1;
        step(1);
        pulse_in = 1'b0;
        chk("rt_pend", int'(pend_cnt), 0);
        wait_idle("rt");
`else
        // Three back-to-back strobes: two are queued and replayed with one gap cycle between windows.
        width_cfg = 8'd2;
        pulse_in  = 1'b1;
        e         = cyc + 1;
        push_win(e, 2);
        push_win(e + 3, 2);
        push_win(e + 6, 2);
        step(1);
        chk("q3_pend_1", int'(pend_cnt), 0);
        step(1);
        chk("q3_pend_2", int'(pend_cnt), 1);
        step(1);
        pulse_in = 1'b0;
        chk("q3_pend_3", int'(pend_cnt), 2);
        peak = 2;
        for (int i = 0; i < 10; i++) begin
            if (int'(pend_cnt) > peak) peak = int'(pend_cnt);
            step(1);
        end
        chk("q3_pend_peak", peak, 2);
        wait_idle("q3");

        // Saturation: one strobe opens the window, the next three fill the queue,
        // and the following two are dropped with overflow raised.
        width_cfg = 8'd8;
        pulse_in  = 1'b1;
        e         = cyc + 1;
        push_win(e, 8);
        push_win(e + 9, 8);
        push_win(e + 18, 8);
        push_win(e + 27, 8);
        step(4);
        chk("sat_pend_full", int'(pend_cnt), 3);
        chk("sat_ovf_before", int'(overflow), 0);
        step(1);
        chk("sat_ovf_1", int'(overflow), 1);
        chk("sat_pend_hold", int'(pend_cnt), 3);
        step(1);
        pulse_in = 1'b0;
        chk("sat_ovf_2", int'(overflow), 1);
        step(1);
        chk("sat_ovf_clear", int'(overflow), 0);
        chk("sat_pend_after", int'(pend_cnt), 3);
        wait_idle("sat");

        // Async reset in the middle of a window, with two strobes queued, discards the queue.
        width_cfg = 8'd8;
        pulse_in  = 1'b1;
        e         = cyc + 1;
        push_win(e, 4);
        step(3);
        pulse_in = 1'b0;
        step(1);
        chk("ar_level_pre", int'(level_out), 1);
        chk("ar_pend_pre", int'(pend_cnt), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_level_async", int'(level_out), 0);
        chk("ar_busy_async", int'(busy), 0);
        chk("ar_pend_async", int'(pend_cnt), 0);
        step(2);
        rst_n = 1'b1;
        step(30);
        chk("ar_no_replay_busy", int'(busy), 0);
        chk("ar_sb_empty", win_q.size(), 0);

        // After release, a fresh strobe behaves as it does from IDLE.
        width_cfg = 8'd2;
        pulse_in  = 1'b1;
        e         = cyc + 1;
        push_win(e, 2);
        step(1);
        pulse_in = 1'b0;
        wait_idle("post_rst");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
